// File: rtl/fx_sqrt_arbiter.sv
// rtl/fx_sqrt_arbiter.sv - round-robin front end sharing one iterative fixed-point sqrt engine
// Optional engine watchdog and DRAIN state enabled by defining FX_SQRT_ARB_TIMEOUT_EN.
module fx_sqrt_arbiter #(
    parameter int N_REQ          = 4,
    parameter int WIDTH          = 32,
    parameter int FRAC           = 16,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int ID_W          = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   eng_valid_in,
    output logic [WIDTH-1:0]       eng_y,
    input  logic                   eng_valid_out,
    input  logic [WIDTH-1:0]       eng_sqrt,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [WIDTH-1:0]       resp_data,
    output logic                   resp_err,
    output logic                   busy
);

    if (N_REQ < 2 || FRAC < 0 || FRAC >= WIDTH || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("fx_sqrt_arbiter: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
`ifdef FX_SQRT_ARB_TIMEOUT_EN
        , S_DRAIN
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_q, rr_d;
    logic [WIDTH-1:0]  op_q, op_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              err_q, err_d;

    logic [WIDTH-1:0]  req_op [N_REQ];
    logic              grant_vld;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   cand;
    logic [WIDTH-1:0]  grant_op;

    for (genvar i = 0; i < N_REQ; i++) begin : g_split
        assign req_op[i] = req_data[i*WIDTH +: WIDTH];
    end

    // Search starts one past the last winner so every requester waits at most N_REQ-1 jobs.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(rr_q) + k) % N_REQ);
            if (!grant_vld && req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign grant_op = req_op[grant_idx];

    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

`ifdef FX_SQRT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;
    logic             cnt_last;
    assign cnt_last = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        op_d    = op_q;
        id_d    = id_q;
        data_d  = data_q;
        err_d   = err_q;
`ifdef FX_SQRT_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        to_d    = to_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    op_d = grant_op;
                    id_d = grant_idx;
                    rr_d = grant_idx;
                    if (grant_op == '0) begin
                        data_d  = '0;
                        err_d   = 1'b0;
                        state_d = S_RESP;
                    end else if (grant_op[WIDTH-1]) begin
                        data_d  = '0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef FX_SQRT_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                if (eng_valid_out) begin
                    data_d  = eng_sqrt;
                    err_d   = 1'b0;
                    state_d = S_RESP;
`ifdef FX_SQRT_ARB_TIMEOUT_EN
                end else if (cnt_last) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    to_d    = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
`endif
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
`ifdef FX_SQRT_ARB_TIMEOUT_EN
                    // A timed-out engine may still answer; swallow that late result.
                    if (to_q) begin
                        state_d = S_DRAIN;
                        cnt_d   = '0;
                        to_d    = 1'b0;
                    end
`endif
                end
            end
`ifdef FX_SQRT_ARB_TIMEOUT_EN
            S_DRAIN: begin
                if (eng_valid_out || cnt_last) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rr_q    <= ID_W'(N_REQ - 1);
            op_q    <= '0;
            id_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
`ifdef FX_SQRT_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            op_q    <= op_d;
            id_q    <= id_d;
            data_q  <= data_d;
            err_q   <= err_d;
`ifdef FX_SQRT_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            to_q    <= to_d;
`endif
        end
    end

    assign eng_valid_in = (state_q == S_ISSUE);
    assign eng_y        = op_q;
    assign resp_valid   = (state_q == S_RESP);
    assign resp_id      = id_q;
    assign resp_data    = data_q;
    assign resp_err     = err_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_fx_sqrt_arbiter.sv
// tb/tb_fx_sqrt_arbiter.sv - self-checking bench for fx_sqrt_arbiter with a fixed-latency engine model
module tb_fx_sqrt_arbiter;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int L  = 5;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_ready;
    logic [N*W-1:0] req_data;
    logic           eng_valid_in, eng_valid_out;
    logic [W-1:0]   eng_y, eng_sqrt;
    logic           resp_valid, resp_ready, resp_err, busy;
    logic [1:0]     resp_id;
    logic [W-1:0]   resp_data;

    always #5 clk = ~clk;

    fx_sqrt_arbiter #(.N_REQ(N), .WIDTH(W), .FRAC(16), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .eng_valid_in(eng_valid_in), .eng_y(eng_y), .eng_valid_out(eng_valid_out), .eng_sqrt(eng_sqrt),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data),
        .resp_err(resp_err), .busy(busy)
    );

    function automatic logic [W-1:0] fsqrt(logic [W-1:0] x);
        longint unsigned v, r, t;
        if (x == '0 || x[W-1]) return '0;
        v = longint'(x) << 16;
        r = 0;
        for (int i = 23; i >= 0; i--) begin
            t = r | (64'd1 << i);
            if (t * t <= v) r = t;
        end
        return W'(r);
    endfunction

    // Engine model: result pulse L cycles after the start pulse.
    int           eng_cnt = 0;
    logic         eng_en, stray;
    logic [W-1:0] eng_res = '0;
    always @(posedge clk) begin
        if (eng_valid_in && eng_en) begin
            eng_cnt <= L;
            eng_res <= fsqrt(eng_y);
        end else if (eng_cnt > 0) begin
            eng_cnt <= eng_cnt - 1;
        end
    end
    assign eng_valid_out = stray | (eng_cnt == 1);
    assign eng_sqrt      = eng_res;

    typedef struct { int id; logic [W-1:0] data; logic err; } exp_t;
    typedef struct { int id; logic [W-1:0] op; logic [W-1:0] exp_data; logic exp_err; } vec_t;

    exp_t         sb[$];
    exp_t         exp_src[N][$];
    logic [W-1:0] src_q[N][$];
    int           grants[$];
    vec_t         vecs[9];

    int n_checks = 0, n_errors = 0;
    int cyc = 0, hs_cyc = -1, eng_cyc = -1, resp_first = -1, resp_hs_cyc = -1, eng_pulses = 0;
    int model_rr = N - 1;
    logic [W-1:0] eng_y_seen;
    logic prev_rv = 1'b0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int model_grant(logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            int idx = (model_rr + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic bit any_src();
        for (int i = 0; i < N; i++) if (src_q[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = (src_q[i].size() > 0);
            req_data[i*W +: W] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
        end
    endtask

    task automatic monitor(output logic [N-1:0] pops);
        logic [N-1:0] hs;
        int g, mg;
        exp_t e;
        pops = '0;
        hs   = req_valid & req_ready;
        if (busy) begin
            check("ready_while_busy", req_ready, '0);
        end else if (req_valid != '0 && !rst) begin
            mg = model_grant(req_valid);
            check("ready_onehot", $onehot(req_ready), 1);
            check("grant", req_ready, N'(1) << mg);
        end
        if (hs != '0) begin
            g = 0;
            for (int i = 0; i < N; i++) if (hs[i]) g = i;
            hs_cyc   = cyc;
            model_rr = g;
            grants.push_back(g);
            if (exp_src[g].size() > 0) sb.push_back(exp_src[g].pop_front());
            pops[g] = 1'b1;
        end
        if (eng_valid_in) begin
            eng_pulses++;
            eng_cyc    = cyc;
            eng_y_seen = eng_y;
        end
        if (resp_valid && !prev_rv) resp_first = cyc;
        prev_rv = resp_valid;
        if (resp_valid && resp_ready) begin
            resp_hs_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected_resp", 1, 0);
            end else begin
                e = sb.pop_front();
                check("resp_id", resp_id, e.id);
                check("resp_data", resp_data, e.data);
                check("resp_err", resp_err, e.err);
            end
        end
    endtask

    task automatic cycle();
        logic [N-1:0] pops;
        #1;
        monitor(pops);
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) if (pops[i]) void'(src_q[i].pop_front());
        drive_inputs();
    endtask

    task automatic push_job(int id, logic [W-1:0] op, logic [W-1:0] d, logic err);
        exp_t e;
        e = '{id: id, data: d, err: err};
        src_q[id].push_back(op);
        exp_src[id].push_back(e);
        drive_inputs();
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            exp_src[i].delete();
        end
        sb.delete();
        drive_inputs();
    endtask

    task automatic wait_idle(string name);
        int n = 0;
        while ((busy || sb.size() > 0 || any_src()) && n < 200) begin
            cycle();
            n++;
        end
        check({"timeout_", name}, (n < 200), 1);
    endtask

    task automatic check_reset_outputs(string name);
        check({name, "_req_ready"}, req_ready, '0);
        check({name, "_eng_valid_in"}, eng_valid_in, 0);
        check({name, "_eng_y"}, eng_y, '0);
        check({name, "_resp_valid"}, resp_valid, 0);
        check({name, "_resp_id"}, resp_id, '0);
        check({name, "_resp_data"}, resp_data, '0);
        check({name, "_resp_err"}, resp_err, 0);
        check({name, "_busy"}, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, pulses0, n;
        int order[5];
        bit byp;
        vecs[0] = '{1, 32'h0004_0000, 32'h0002_0000, 1'b0};
        vecs[1] = '{2, 32'h0001_0000, 32'h0001_0000, 1'b0};
        vecs[2] = '{0, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[3] = '{3, 32'h8000_0000, 32'h0000_0000, 1'b1};
        vecs[4] = '{0, 32'h0009_0000, 32'h0003_0000, 1'b0};
        vecs[5] = '{3, 32'h0002_4000, 32'h0001_8000, 1'b0};
        vecs[6] = '{2, 32'h0000_0001, 32'h0000_0100, 1'b0};
        vecs[7] = '{1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[8] = '{0, 32'h7FFF_FFFF, 32'h00B5_04F3, 1'b0};
        order   = '{0, 1, 2, 3, 0};

        rst = 1'b1; resp_ready = 1'b1; eng_en = 1'b1; stray = 1'b0;
        drive_inputs();
        cycle();
        cycle();
        rst = 1'b0;
        model_rr = N - 1;
        #1;
        check_reset_outputs("reset");

        // Table-driven single jobs with latency checks.
        for (int v = 0; v < 9; v++) begin
            pulses0 = eng_pulses;
            push_job(vecs[v].id, vecs[v].op, vecs[v].exp_data, vecs[v].exp_err);
            wait_idle("vec");
            byp = (vecs[v].op == '0) || vecs[v].op[W-1];
            if (byp) begin
                check("bypass_latency", resp_first, hs_cyc + 1);
                check("bypass_no_engine", eng_pulses, pulses0);
            end else begin
                check("issue_latency", eng_cyc, hs_cyc + 1);
                check("issue_eng_y", eng_y_seen, vecs[v].op);
                check("resp_latency", resp_first, hs_cyc + 2 + L);
                check("one_engine_pulse", eng_pulses, pulses0 + 1);
            end
        end

        // Fairness: all requesters busy, rotation from a fresh reset.
        clear_model();
        rst = 1'b1; cycle(); rst = 1'b0; model_rr = N - 1;
        grants.delete();
        pulses0 = eng_pulses;
        push_job(0, 32'h0001_0000, fsqrt(32'h0001_0000), 1'b0);
        push_job(0, 32'h0004_0000, fsqrt(32'h0004_0000), 1'b0);
        push_job(1, 32'h0009_0000, fsqrt(32'h0009_0000), 1'b0);
        push_job(2, 32'h0019_0000, fsqrt(32'h0019_0000), 1'b0);
        push_job(3, 32'h0024_0000, fsqrt(32'h0024_0000), 1'b0);
        wait_idle("fair");
        check("fair_count", grants.size(), 5);
        for (int i = 0; i < 5 && i < grants.size(); i++) check("fair_order", grants[i], order[i]);
        check("fair_pulses", eng_pulses, pulses0 + 5);

        // Backpressure: response held for 10 cycles, next grant right after release.
        resp_ready = 1'b0;
        push_job(1, 32'h0009_0000, 32'h0003_0000, 1'b0);
        push_job(2, 32'h0001_0000, 32'h0001_0000, 1'b0);
        for (n = 0; n < 40 && !resp_valid; n++) cycle();
        check("bp_resp_seen", resp_valid, 1);
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("bp_valid_hold", resp_valid, 1);
            if (sb.size() > 0) begin
                check("bp_id_hold", resp_id, sb[0].id);
                check("bp_data_hold", resp_data, sb[0].data);
            end
            check("bp_ready_low", req_ready, '0);
        end
        resp_ready = 1'b1;
        base = grants.size();
        cycle();
        for (n = 0; n < 5 && grants.size() == base; n++) cycle();
        check("bp_next_grant", hs_cyc, resp_hs_cyc + 1);
        wait_idle("bp");

        // Reset while waiting on the engine, then a stray result pulse.
        eng_en = 1'b0;
        push_job(2, 32'h0004_0000, 32'h0002_0000, 1'b0);
        for (n = 0; n < 20 && !eng_valid_in; n++) cycle();
        cycle();
        cycle();
        check("rst_busy_before", busy, 1);
        clear_model();
        rst = 1'b1; cycle(); rst = 1'b0; model_rr = N - 1;
        #1;
        check_reset_outputs("midjob_rst");
        cycle();
        stray = 1'b1; cycle(); stray = 1'b0; cycle();
        check("stray_no_resp", resp_valid, 0);
        check("stray_not_busy", busy, 0);
        eng_en = 1'b1;
        base = grants.size();
        push_job(3, 32'h0001_0000, 32'h0001_0000, 1'b0);
        push_job(0, 32'h0004_0000, 32'h0002_0000, 1'b0);
        wait_idle("after_rst");
        check("after_rst_count", grants.size(), base + 2);
        if (grants.size() >= base + 2) begin
            check("after_rst_first", grants[base], 0);
            check("after_rst_second", grants[base+1], 3);
        end

`ifdef FX_SQRT_ARB_TIMEOUT_EN
        // Engine never answers: watchdog error, then DRAIN blocks new grants.
        eng_en = 1'b0;
        push_job(1, 32'h0004_0000, 32'h0000_0000, 1'b1);
        for (n = 0; n < 20 && !eng_valid_in; n++) cycle();
        for (n = 0; n < 40 && !(resp_valid && prev_rv == 1'b0 && resp_first == cyc); n++) begin
            cycle();
            if (resp_valid) break;
        end
        eng_en = 1'b1;
        base = grants.size();
        push_job(2, 32'h0001_0000, 32'h0001_0000, 1'b0);
        cycle();
        check("to_resp_time", resp_first, eng_cyc + 1 + TO);
        for (n = 0; n < 40 && grants.size() == base; n++) cycle();
        check("drain_release", hs_cyc, resp_hs_cyc + 1 + TO);
        wait_idle("timeout");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fx_sqrt_arbiter.md
Name: fx_sqrt_arbiter

Overview:
- Round-robin scheduler that shares one iterative fixed-point square-root engine among N_REQ requesters, e.g. path generators needing sqrt(dt) or volatility terms.
- Exactly one job is in flight at a time. The block captures a request, issues a single-cycle start pulse to the engine, waits for the engine's result pulse, then returns the result tagged with the requester ID.
- Inputs of zero or negative value bypass the engine entirely.

Parameters:
- N_REQ, 4, number of requesters (≥2).
- WIDTH, 32, data width (signed two's-complement fixed point).
- FRAC, 16, fractional bits (Q16.16 default); passed through for documentation and bench use only.
- TIMEOUT_CYCLES, 64, engine watchdog limit; used only with the optional feature.
- ID_W, derived localparam = max(1, clog2(N_REQ)).

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_data  in  N_REQ*WIDTH  operand; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  out  N_REQ  one-hot (or zero) acceptance.
- eng_valid_in  out  1  single-cycle start pulse to the engine.
- eng_y  out  WIDTH  engine operand, stable from the pulse until the result returns.
- eng_valid_out  in  1  engine result pulse.
- eng_sqrt  in  WIDTH  engine result, sampled only with eng_valid_out.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response accept.
- resp_id  out  ID_W  requester index of the response.
- resp_data  out  WIDTH  square root result.
- resp_err  out  1  1 = negative operand (or timeout, see Optional Feature); resp_data is 0.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state = IDLE; rr_ptr = N_REQ-1, so requester 0 has highest priority first.
  - All outputs 0, including eng_y, resp_data and resp_id.
  - Reset mid-job abandons the job. A late eng_valid_out arriving after reset is ignored, because the block is in IDLE.
- State machine: IDLE, ISSUE, WAIT, RESP (plus DRAIN with the optional feature).
- IDLE:
  - Grant = first requester with req_valid set, searching rr_ptr+1, rr_ptr+2, … modulo N_REQ.
  - req_ready[g] = 1 combinationally for the granted requester only; all other bits 0. No grant means req_ready = 0.
  - On handshake (req_valid[g] & req_ready[g]): capture operand op and id = g; rr_ptr <= g.
  - op == 0 -> RESP with resp_data = 0, resp_err = 0.
  - op[WIDTH-1] == 1 (negative) -> RESP with resp_data = 0, resp_err = 1.
  - Otherwise -> ISSUE.
- ISSUE: eng_valid_in = 1 for exactly this one cycle, eng_y = op. Next state WAIT unconditionally.
- WAIT:
  - eng_valid_in = 0.
  - On eng_valid_out: register eng_sqrt into resp_data, resp_err = 0, go to RESP.
  - An eng_valid_out in any state other than WAIT/DRAIN is ignored.
- RESP:
  - resp_valid = 1; resp_id, resp_data and resp_err held stable until resp_ready.
  - On resp_ready -> IDLE. req_ready stays 0 during RESP.
  - The next request can be accepted the cycle after resp_ready.
- Latency, with engine latency L cycles from start pulse to result pulse:
  - Accept at T; eng_valid_in at T+1; eng_valid_out at T+1+L; resp_valid at T+2+L.
  - Bypass path: resp_valid at T+1.
- Fairness: with all requesters asserted continuously, grants rotate 0,1,2,3,0,… A requester waits at most N_REQ-1 jobs.
- A requester dropping req_valid before it is granted loses nothing; request data is only sampled at handshake.
- busy = (state != IDLE).

Optional Feature:
- Macro: FX_SQRT_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each cycle in WAIT.
  - If it reaches TIMEOUT_CYCLES without eng_valid_out: go to RESP with resp_data = 0, resp_err = 1, then to DRAIN instead of IDLE after resp_ready.
  - DRAIN keeps req_ready = 0 and discards the engine result. It exits to IDLE on eng_valid_out or after TIMEOUT_CYCLES further cycles, whichever comes first.
- Undefined: no counter and no DRAIN state; WAIT waits indefinitely.

Test Plan:
- Single request, engine model latency 5: requester 1 sends 0x00040000 -> eng_valid_in pulse with eng_y = 0x00040000 at T+1; resp_valid at T+7 with resp_id = 1, resp_data = 0x00020000, resp_err = 0.
- All four requesters valid, resp_ready tied 1 -> grant order 0,1,2,3,0; each req_ready strictly one-hot; never two jobs in flight.
- Boundary operands: 0x00000000 -> resp_valid at T+1, data 0, err 0, no eng_valid_in pulse. 0x80000000 -> data 0, err 1, no eng_valid_in pulse.
- Backpressure: resp_ready low for 10 cycles -> resp_valid, resp_id and resp_data stable; req_ready all 0; release -> IDLE, next grant the following cycle.
- rst asserted in WAIT, then a stray eng_valid_out 2 cycles later -> all outputs 0 and no response; the next request is then served by requester 0 first.
- With FX_SQRT_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8, engine never responds -> resp_err = 1 and data 0 at WAIT entry + 8; DRAIN blocks req_ready for up to 8 further cycles, then IDLE.
